// File: rtl/aclk_time_entry.sv
// ---------------------------------------------------------------------------
// aclk_time_entry
//   Keypad entry controller in front of the alarm clock core. It takes a mode
//   key (SET_TIME / SET_ALARM) and then four BCD digits HH:MM. Each digit is
//   checked when it arrives, so the load bus only ever carries a legal time
//   (hour <= 23, minute <= 59). A complete entry loads the bus and raises a
//   registered LD_time or LD_alarm strobe for LD_CYCLES cycles.
//
//   Handshake: key_valid is a single-cycle event qualifier. key_code is
//   sampled only on a rising clk edge where key_valid is high. There is no
//   back-pressure: a key that arrives while the block cannot use it (IDLE
//   non-mode keys, any key in LOAD) is dropped silently.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   key_valid, key_code : key event; 0-9 digit, A SET_TIME, B SET_ALARM,
//                         C CANCEL, D-F ignored
//   H_in1/H_in0/M_in1/M_in0 : load bus to the core (holds last loaded time)
//   LD_time / LD_alarm  : load strobes, never high together
//   busy                : high outside IDLE
//   digit_idx           : digits accepted so far in the current entry
//   err                 : one-cycle pulse on a rejected digit
//   timeout             : one-cycle pulse when an entry is abandoned
// ---------------------------------------------------------------------------
module aclk_time_entry #(
    parameter int TIMEOUT_TICKS = 50,
    parameter int LD_CYCLES     = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       busy,
    output logic [1:0] digit_idx,
    output logic       err,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENTRY = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    // Counters hold "cycles remaining minus one" so expiry is a compare to 0.
    localparam int TW = $clog2(TIMEOUT_TICKS);
    localparam int LW = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;
    localparam logic [TW-1:0] T_RELOAD  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [LW-1:0] LD_RELOAD = LW'(LD_CYCLES - 1);

    localparam logic [3:0] K_SET_TIME  = 4'hA;
    localparam logic [3:0] K_SET_ALARM = 4'hB;
    localparam logic [3:0] K_CANCEL    = 4'hC;

    logic [1:0]    state;
    logic          mode_alarm;
    logic [1:0]    idx;
    logic [1:0]    stg_h1;
    logic [3:0]    stg_h0;
    logic [3:0]    stg_m1;
    logic [TW-1:0] tcnt;
    logic [LW-1:0] lcnt;

    logic is_digit;
    logic is_set;
    logic is_cancel;
    logic digit_ok;

    assign is_digit  = (key_code <= 4'd9);
    assign is_set    = (key_code == K_SET_TIME) || (key_code == K_SET_ALARM);
    assign is_cancel = (key_code == K_CANCEL);

    // Legal range depends on position; hour units is limited to 0-3 when the
    // staged hour tens is 2, which keeps the hour at or below 23.
    always_comb begin
        digit_ok = 1'b0;
        case (idx)
            2'd0:    digit_ok = (key_code <= 4'd2);
            2'd1:    digit_ok = (stg_h1 == 2'd2) ? (key_code <= 4'd3) : (key_code <= 4'd9);
            2'd2:    digit_ok = (key_code <= 4'd5);
            default: digit_ok = (key_code <= 4'd9);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            mode_alarm <= 1'b0;
            idx        <= 2'd0;
            stg_h1     <= 2'd0;
            stg_h0     <= 4'd0;
            stg_m1     <= 4'd0;
            tcnt       <= '0;
            lcnt       <= '0;
            H_in1      <= 2'd0;
            H_in0      <= 4'd0;
            M_in1      <= 4'd0;
            M_in0      <= 4'd0;
            LD_time    <= 1'b0;
            LD_alarm   <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            err     <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_valid && is_set) begin
                        state      <= S_ENTRY;
                        mode_alarm <= (key_code == K_SET_ALARM);
                        idx        <= 2'd0;
                        stg_h1     <= 2'd0;
                        stg_h0     <= 4'd0;
                        stg_m1     <= 4'd0;
                        tcnt       <= T_RELOAD;
                    end
                end
                S_ENTRY: begin
                    if (key_valid) begin
                        // Any key event, legal or not, restarts the inactivity window.
                        tcnt <= T_RELOAD;
                        if (is_digit) begin
                            if (digit_ok) begin
                                case (idx)
                                    2'd0: stg_h1 <= key_code[1:0];
                                    2'd1: stg_h0 <= key_code;
                                    2'd2: stg_m1 <= key_code;
                                    default: begin
                                        // Final digit goes straight onto the bus with the strobe.
                                        H_in1    <= stg_h1;
                                        H_in0    <= stg_h0;
                                        M_in1    <= stg_m1;
                                        M_in0    <= key_code;
                                        LD_time  <= !mode_alarm;
                                        LD_alarm <= mode_alarm;
                                        lcnt     <= LD_RELOAD;
                                        state    <= S_LOAD;
                                    end
                                endcase
                                idx <= idx + 2'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (is_set) begin
                            mode_alarm <= (key_code == K_SET_ALARM);
                            idx        <= 2'd0;
                            stg_h1     <= 2'd0;
                            stg_h0     <= 4'd0;
                            stg_m1     <= 4'd0;
                        end else if (is_cancel) begin
                            state <= S_IDLE;
                            idx   <= 2'd0;
                        end
                    end else if (tcnt == '0) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                        idx     <= 2'd0;
                    end else begin
                        tcnt <= tcnt - 1'b1;
                    end
                end
                S_LOAD: begin
                    if (lcnt == '0) begin
                        LD_time  <= 1'b0;
                        LD_alarm <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        lcnt <= lcnt - 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    idx      <= 2'd0;
                    LD_time  <= 1'b0;
                    LD_alarm <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign digit_idx = idx;

endmodule

// File: tb/tb_aclk_time_entry.sv
// ---------------------------------------------------------------------------
// tb_aclk_time_entry
//   Directed scenarios followed by randomized key traffic. A behavioural model
//   (integer digit list, quiet-cycle count, load countdown) predicts every
//   output after each clock edge and the outputs are compared at edge + 1.
// ---------------------------------------------------------------------------
module tb_aclk_time_entry;

    localparam int TIMEOUT_TICKS = 50;
    localparam int LD_CYCLES     = 1;

    logic       clk;
    logic       reset_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       busy;
    logic [1:0] digit_idx;
    logic       err;
    logic       timeout;

    int n_checks;
    int n_fail;

    aclk_time_entry #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .LD_CYCLES    (LD_CYCLES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .busy     (busy),
        .digit_idx(digit_idx),
        .err      (err),
        .timeout  (timeout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_phase;   // 0 idle, 1 collecting digits, 2 loading
    bit          m_alarm;
    int          m_dig[4];
    int          m_n;
    int          m_quiet;
    int          m_left;
    logic [15:0] m_bus;
    bit          m_err;
    bit          m_to;

    task automatic model_reset();
        m_phase = 0; m_alarm = 0; m_n = 0; m_quiet = 0; m_left = 0;
        m_bus = 16'h0000; m_err = 0; m_to = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endtask

    function automatic bit digit_legal(int pos, int d, int h1);
        if (pos == 0) return d <= 2;
        if (pos == 1) return (h1 == 2) ? (d <= 3) : (d <= 9);
        if (pos == 2) return d <= 5;
        return d <= 9;
    endfunction

    task automatic model_step(input bit kv, input int kc);
        m_err = 0;
        m_to  = 0;
        if (m_phase == 2) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 0;
        end else if (m_phase == 1) begin
            if (kv) begin
                m_quiet = 0;
                if (kc <= 9) begin
                    if (digit_legal(m_n, kc, m_dig[0])) begin
                        m_dig[m_n] = kc;
                        m_n = m_n + 1;
                        if (m_n == 4) begin
                            m_bus   = 16'(m_dig[0] * 4096 + m_dig[1] * 256 + m_dig[2] * 16 + m_dig[3]);
                            m_phase = 2;
                            m_left  = LD_CYCLES;
                            m_n     = 0;
                        end
                    end else begin
                        m_err = 1;
                    end
                end else if (kc == 10 || kc == 11) begin
                    m_alarm = (kc == 11);
                    m_n = 0;
                    for (int i = 0; i < 4; i++) m_dig[i] = 0;
                end else if (kc == 12) begin
                    m_phase = 0;
                    m_n = 0;
                end
            end else begin
                m_quiet = m_quiet + 1;
                if (m_quiet >= TIMEOUT_TICKS) begin
                    m_to = 1;
                    m_phase = 0;
                    m_n = 0;
                end
            end
        end else begin
            if (kv && (kc == 10 || kc == 11)) begin
                m_phase = 1;
                m_alarm = (kc == 11);
                m_n = 0;
                m_quiet = 0;
                for (int i = 0; i < 4; i++) m_dig[i] = 0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] bus_val();
        return {2'b00, H_in1, H_in0, M_in1, M_in0};
    endfunction

    function automatic logic [6:0] ctl_val();
        return {LD_time, LD_alarm, busy, digit_idx, err, timeout};
    endfunction

    function automatic logic [6:0] ctl_exp();
        logic [1:0] n2;
        n2 = (m_phase == 1) ? 2'(m_n) : 2'd0;
        return {(m_phase == 2) && !m_alarm, (m_phase == 2) && m_alarm, m_phase != 0,
                n2, m_err, m_to};
    endfunction

    task automatic compare_all();
        check("bus", 32'(bus_val()), 32'(m_bus));
        check("ctl", 32'(ctl_val()), 32'(ctl_exp()));
        check("strobe_excl", 32'(LD_time & LD_alarm), 32'd0);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; applies the key for the next edge, then checks.
    task automatic tick(input bit kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_step(kv, int'(kc));
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        compare_all();
    endtask

    task automatic key(input logic [3:0] kc);
        tick(1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int to_seen;
        int pct;
        bit kv;
        logic [3:0] kc;

        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_reset();
        #23;
        check("reset_bus", 32'(bus_val()), 32'h0);
        check("reset_ctl", 32'(ctl_val()), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: plain time load
        key(4'hA); key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        check("t1_ld_time", 32'(LD_time), 32'd1);
        check("t1_bus", 32'(bus_val()), 32'h1234);
        idle(1);
        check("t1_after", 32'({LD_time, LD_alarm, busy}), 32'd0);

        // 2: rejected hour digit, then alarm load
        key(4'hB); key(4'h2); key(4'h4);
        check("t2_err", 32'(err), 32'd1);
        check("t2_idx", 32'(digit_idx), 32'd1);
        key(4'h3); key(4'h5); key(4'h9);
        check("t2_ld_alarm", 32'({LD_time, LD_alarm}), 32'b01);
        check("t2_bus", 32'(bus_val()), 32'h2359);
        idle(2);

        // 3: cancel keeps bus
        key(4'hA); key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        idle(2);
        key(4'hA); key(4'h1); key(4'h6); key(4'hC);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_bus", 32'(bus_val()), 32'h1234);

        // 4: timeout, then a key one cycle before expiry
        key(4'hA); key(4'h0);
        idle(TIMEOUT_TICKS - 1);
        check("t4_pre", 32'({busy, timeout}), 32'b10);
        idle(1);
        check("t4_timeout", 32'({busy, timeout}), 32'b01);
        key(4'hA); key(4'h0);
        idle(TIMEOUT_TICKS - 1);
        key(4'h1);
        to_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'h0);
            to_seen += int'(timeout);
        end
        check("t4_no_timeout", 32'(to_seen), 32'd0);
        key(4'hC);

        // 5: reset during the strobe
        key(4'hA); key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        check("t5_strobe", 32'(LD_time), 32'd1);
        #1;
        do_reset();
        check("t5_bus", 32'(bus_val()), 32'h0);

        // 6: restart with another mode; digits in IDLE do nothing
        key(4'h6); key(4'h7);
        check("t6_idle", 32'(busy), 32'd0);
        key(4'hA); key(4'h1); key(4'hB); key(4'h0); key(4'h7); key(4'h3); key(4'h0);
        check("t6_ld", 32'({LD_time, LD_alarm}), 32'b01);
        check("t6_bus", 32'(bus_val()), 32'h0730);
        idle(2);

        // randomized traffic with varying key density
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 2))
                0:       pct = 60;
                1:       pct = 20;
                default: pct = 2;
            endcase
            for (int c = 0; c < 100; c++) begin
                kv = ($urandom_range(0, 99) < pct);
                if ($urandom_range(0, 9) < 7) kc = 4'($urandom_range(0, 9));
                else                          kc = 4'($urandom_range(10, 15));
                tick(kv, kc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
